bram_fifo_ctrl: RTL

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

---
 rtl/bram_fifo_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller around an external 512x32 registered-output dual-port RAM.
// One word may sit in the RAM output register (out_valid); up to 512 more live in the RAM.
module bram_fifo_ctrl #(
  parameter int unsigned AFULL_LVL  = 480,
  parameter int unsigned AEMPTY_LVL = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [31:0] in_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [9:0]  level,
  output logic        almost_full,
  output logic        almost_empty,
  output logic        ram_wen_n,
  output logic        ram_ren_n,
  output logic [8:0]  ram_waddr,
  output logic [8:0]  ram_raddr,
  output logic [31:0] ram_d_in,
  output logic [31:0] ram_wenb,
  input  logic [31:0] ram_d_out
);

  localparam logic [9:0] AFULL_L  = 10'(AFULL_LVL);
  localparam logic [9:0] AEMPTY_L = 10'(AEMPTY_LVL);
  localparam logic [9:0] RAM_WORDS = 10'd512;

  logic       active;
  logic [8:0] wr_ptr;
  logic [8:0] rd_ptr;
  logic [9:0] mem_cnt;
  logic [9:0] mem_cnt_nxt;
  logic [9:0] level_nxt;
  logic       out_valid_nxt;
  logic       push;
  logic       pop;
  logic       fetch;

  // active is cleared asynchronously so both RAM strobes drop the instant reset asserts.
  assign in_ready = active & ~flush & (mem_cnt != RAM_WORDS);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign fetch    = active & ~flush & (mem_cnt != 10'd0) & (~out_valid | out_ready);

  assign ram_wen_n = ~push;
  assign ram_waddr = wr_ptr;
  assign ram_d_in  = in_data;
  assign ram_wenb  = in_mask;
  assign ram_ren_n = ~fetch;
  assign ram_raddr = rd_ptr;
  assign out_data  = ram_d_out;

  always_comb begin
    out_valid_nxt = out_valid;
    mem_cnt_nxt   = mem_cnt;
    level_nxt     = 10'd0;
    if (fetch) begin
      out_valid_nxt = 1'b1;
    end else if (pop) begin
      out_valid_nxt = 1'b0;
    end
    mem_cnt_nxt = mem_cnt + {9'd0, push} - {9'd0, fetch};
    if (!flush) begin
      level_nxt = mem_cnt_nxt + {9'd0, out_valid_nxt};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active       <= 1'b0;
      wr_ptr       <= 9'd0;
      rd_ptr       <= 9'd0;
      mem_cnt      <= 10'd0;
      out_valid    <= 1'b0;
      level        <= 10'd0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      active       <= 1'b1;
      level        <= level_nxt;
      almost_full  <= (level_nxt >= AFULL_L);
      almost_empty <= (level_nxt <= AEMPTY_L);
      if (flush) begin
        wr_ptr    <= 9'd0;
        rd_ptr    <= 9'd0;
        mem_cnt   <= 10'd0;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 9'd1;
        end
        if (fetch) begin
          rd_ptr <= rd_ptr + 9'd1;
        end
        mem_cnt   <= mem_cnt_nxt;
        out_valid <= out_valid_nxt;
      end
    end
  end

endmodule
